// File: rtl/mdu_unit_if.sv
// rtl/mdu_unit_if.sv - EX-stage request and HI/LO result bundle for the multiply/divide unit
interface mdu_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, input busy, hi, lo);
   modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multiply/divide unit holding HI/LO with modelled multi-cycle latency
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   mdu_unit_if.slave  bus
);
   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

   state_t      state, state_next;
   logic [3:0]  count;
   logic [31:0] hi_q, lo_q, hold_hi, hold_lo;
   logic        hold_wr;
   logic        op_long, op_is_div;
   logic [63:0] result;
   logic        result_wr;
   logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag;

   assign op_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
   assign op_long   = bus.start && (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);

   // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
   always_comb begin
      result    = '0;
      result_wr = 1'b1;
      a_mag     = (bus.op == OP_DIV && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
      b_mag     = (bus.op == OP_DIV && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
      b_div     = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag     = a_mag / b_div;
      r_mag     = a_mag % b_div;
      case (bus.op)
         OP_MULT:  result = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
         OP_MULTU: result = {32'd0, bus.a} * {32'd0, bus.b};
         OP_DIV: begin
            result[63:32] = bus.a[31] ? (~r_mag + 32'd1) : r_mag;
            result[31:0]  = (bus.a[31] ^ bus.b[31]) ? (~q_mag + 32'd1) : q_mag;
            result_wr     = (bus.b != 32'd0);
         end
         OP_DIVU: begin
            result    = {r_mag, q_mag};
            result_wr = (bus.b != 32'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (op_long) state_next = RUN;
         RUN:  if (count == 4'd1) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Requests arriving while RUN are dropped; the hazard unit should never send them.
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         hold_hi <= '0;
         hold_lo <= '0;
         hold_wr <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (state == IDLE) begin
         if (op_long) begin
            hold_hi <= result[63:32];
            hold_lo <= result[31:0];
            hold_wr <= result_wr;
            count   <= op_is_div ? DIV_LAT : MULT_LAT;
         end else if (bus.start && bus.op == OP_MTHI) begin
            hi_q <= bus.a;
         end else if (bus.start && bus.op == OP_MTLO) begin
            lo_q <= bus.a;
         end
      end else begin
         count <= count - 4'd1;
         if (count == 4'd1 && hold_wr) begin
            hi_q <= hold_hi;
            lo_q <= hold_lo;
         end
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed and randomized checks of mdu_unit against an arithmetic model
module tb_mdu_unit;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   passed = 0;
   int   failed = 0;
   logic [31:0] m_hi, m_lo;

   mdu_unit_if bus();

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Architectural result from plain 64-bit arithmetic; divide by zero keeps HI/LO.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] cur);
      longint sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd1: return sa * sb;
         3'd2: return ua * ub;
         3'd3: begin
            if (b == 32'd0) return cur;
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd4: begin
            if (b == 32'd0) return cur;
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
         default: return cur;
      endcase
   endfunction

   task automatic run_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int n, input int inject_at, input string tag);
      logic [63:0] exp;
      logic [31:0] old_hi, old_lo;
      int cnt;
      bit held;
      exp    = model(op, a, b, {m_hi, m_lo});
      old_hi = m_hi;
      old_lo = m_lo;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      cnt  = 0;
      held = 1'b1;
      while (bus.busy === 1'b1 && cnt < 40) begin
         cnt = cnt + 1;
         if (bus.hi !== old_hi || bus.lo !== old_lo) held = 1'b0;
         if (cnt == inject_at) begin
            bus.start = 1'b1;
            bus.op    = 3'd6;
            bus.a     = 32'hDEADBEEF;
         end else begin
            bus.start = 1'b0;
            bus.op    = 3'd0;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.op    = 3'd0;
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      check({tag, " busy_len"}, 32'(cnt), 32'(n));
      check({tag, " hold"}, {31'd0, held}, 32'd1);
      check({tag, " hi"}, bus.hi, m_hi);
      check({tag, " lo"}, bus.lo, m_lo);
   endtask

   task automatic idle_op(input logic [2:0] op, input logic [31:0] a, input string tag);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = 3'd0;
      if (op == 3'd5) m_hi = a;
      if (op == 3'd6) m_lo = a;
      check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, " hi"}, bus.hi, m_hi);
      check({tag, " lo"}, bus.lo, m_lo);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      bit quiet;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      check("reset busy", {31'd0, bus.busy}, 32'd0);
      check("reset hi", bus.hi, 32'd0);
      check("reset lo", bus.lo, 32'd0);
      reset = 1'b0;
      m_hi  = '0;
      m_lo  = '0;

      run_long(3'd1, 32'hFFFFFFFF, 32'd2, 5, 0, "mult");
      run_long(3'd2, 32'hFFFFFFFF, 32'd2, 5, 0, "multu");
      run_long(3'd3, 32'hFFFFFFF9, 32'd2, 10, 0, "div_neg");
      run_long(3'd4, 32'd7, 32'd2, 10, 0, "divu");
      run_long(3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 0, "div_ovf");
      idle_op(3'd5, 32'h11111111, "mthi");
      idle_op(3'd6, 32'h22222222, "mtlo");
      run_long(3'd4, 32'h00012345, 32'd0, 10, 0, "divu_zero");
      run_long(3'd3, 32'hFFFF0000, 32'd0, 10, 0, "div_zero");
      idle_op(3'd7, 32'hCAFEF00D, "op7");
      idle_op(3'd0, 32'hCAFEF00D, "op0");
      run_long(3'd1, 32'h12345678, 32'h9ABCDEF0, 5, 2, "start_busy");

      bus.start = 1'b1;
      bus.op    = 3'd3;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = 3'd0;
      repeat (3) @(negedge clk);
      check("rst_mid busy_before", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
      check("rst_mid busy", {31'd0, bus.busy}, 32'd0);
      check("rst_mid hi", bus.hi, 32'd0);
      check("rst_mid lo", bus.lo, 32'd0);
      quiet = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) quiet = 1'b0;
      end
      check("rst_mid no_late_commit", {31'd0, quiet}, 32'd1);
      run_long(3'd1, $urandom, $urandom, 5, 0, "after_rst");

      for (int i = 0; i < 20; i++) begin
         rop = 3'($urandom_range(1, 4));
         ra  = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFFFFFF;
            2:       rb = 32'($urandom_range(1, 9));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
         run_long(rop, ra, rb, (rop <= 3'd2) ? 5 : 10, 0, $sformatf("rand%0d", i));
         if ($urandom_range(0, 3) == 0)
            idle_op(3'($urandom_range(5, 6)), $urandom, $sformatf("rand_mt%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
